modn_counter: RTL and testbench

//  Parametrised modulo-N counter; generalises the fixed mod-32 counter.

---
 rtl/modn_counter.sv | 114 +++++++++++
 tb/tb_modn_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/modn_counter.sv
// Modulo-N event/timebase counter: up/down, clear, load, one-shot stop with sticky done,
// registered wrap pulse (rt) for cascading into the next stage's en.
module modn_counter #(
  parameter int MODULUS   = 32,
  parameter int WIDTH     = 5,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             rt,
  output logic             done,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the load range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  if (MODULUS < 2 || RESET_VAL < 0 || RESET_VAL >= MODULUS ||
      (longint'(1) << WIDTH) < longint'(MODULUS)) begin : g_bad_params
    $error("modn_counter: illegal MODULUS/WIDTH/RESET_VAL combination");
  end

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             rt_reg, rt_next;
  logic             done_reg, done_next;
  logic             load_err_reg, load_err_next;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] stepped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_COUNT;
      count_reg    <= RST_VAL;
      rt_reg       <= 1'b0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      rt_reg       <= rt_next;
      done_reg     <= done_next;
      load_err_reg <= load_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rt_next       = 1'b0;
    done_next     = done_reg;
    load_err_next = 1'b0;
    term          = dir ? MAX_VAL : '0;
    stepped       = dir ? (count_reg + ONE) : (count_reg - ONE);

    if (clr) begin
      count_next = '0;
      done_next  = 1'b0;
      state_next = ST_COUNT;
    end else if (load) begin
      done_next  = 1'b0;
      state_next = ST_COUNT;
      if ({1'b0, load_val} < MOD_EXT) begin
        count_next = load_val;
      end else begin
        count_next    = '0;
        load_err_next = 1'b1;
      end
    end else if (en && state_reg == ST_COUNT) begin
      if (oneshot) begin
        // Already at terminal: latch done without stepping; otherwise stop on landing.
        if (count_reg == term) begin
          done_next  = 1'b1;
          state_next = ST_DONE;
        end else begin
          count_next = stepped;
          if (stepped == term) begin
            done_next  = 1'b1;
            state_next = ST_DONE;
          end
        end
      end else if (dir && count_reg == MAX_VAL) begin
        count_next = '0;
        rt_next    = 1'b1;
      end else if (!dir && count_reg == '0) begin
        count_next = MAX_VAL;
        rt_next    = 1'b1;
      end else begin
        count_next = stepped;
      end
    end
  end

  assign count    = count_reg;
  assign rt       = rt_reg;
  assign done     = done_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_modn_counter.sv
// Bench for modn_counter: reset, mod-32 up wrap, mod-10 down wrap, vector table for
// one-shot/priority/load corners, and a two-stage mod-10 cascade checked against a model.
module tb_modn_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, dir = 1'b1, oneshot = 1'b0, clr = 1'b0, load = 1'b0;
  logic [4:0] load_val = '0;
  logic       cas_en = 1'b0;

  logic [4:0] c32;  logic rt32, dn32, le32;
  logic [3:0] c10;  logic rt10, dn10, le10;
  logic [3:0] clo;  logic rtlo, dnlo, lelo;
  logic [3:0] chi;  logic rthi, dnhi, lehi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  modn_counter #(.MODULUS(32), .WIDTH(5), .RESET_VAL(0)) d32 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val), .count(c32), .rt(rt32), .done(dn32), .load_err(le32));

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) d10 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(c10), .rt(rt10), .done(dn10), .load_err(le10));

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) dlo (
    .clk(clk), .rst(rst), .en(cas_en), .dir(dir), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(clo), .rt(rtlo), .done(dnlo), .load_err(lelo));

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) dhi (
    .clk(clk), .rst(rst), .en(rtlo), .dir(dir), .oneshot(oneshot), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(chi), .rt(rthi), .done(dnhi), .load_err(lehi));

  typedef struct {
    string nm;
    int    sel;   // 0=d32 1=d10 2=cascade low 3=cascade high
    int    c;
    logic  r, d, le;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic       clr, load;
    logic [3:0] lv;
    logic       en, dir, os;
    int         c;
    logic       r, d, le;
  } vec_t;

  task automatic push(string nm, int sel, int c, logic r, logic d, logic le);
    exp_t e;
    e.nm = nm; e.sel = sel; e.c = c; e.r = r; e.d = d; e.le = le;
    exp_q.push_back(e);
  endtask

  task automatic check(exp_t e);
    int   ac;
    logic ar, ad, ale;
    case (e.sel)
      0:       begin ac = int'(c32); ar = rt32; ad = dn32; ale = le32; end
      1:       begin ac = int'(c10); ar = rt10; ad = dn10; ale = le10; end
      2:       begin ac = int'(clo); ar = rtlo; ad = dnlo; ale = lelo; end
      default: begin ac = int'(chi); ar = rthi; ad = dnhi; ale = lehi; end
    endcase
    total++;
    if (ac !== e.c || ar !== e.r || ad !== e.d || ale !== e.le) begin
      bad++;
      $display("FAIL %s: got count=%0d rt=%b done=%b load_err=%b, want count=%0d rt=%b done=%b load_err=%b",
               e.nm, ac, ar, ad, ale, e.c, e.r, e.d, e.le);
    end else begin
      $display("ok   %s: count=%0d rt=%b done=%b load_err=%b", e.nm, ac, ar, ad, ale);
    end
  endtask

  task automatic flush();
    while (exp_q.size() > 0) check(exp_q.pop_front());
  endtask

  // Advance one clock edge and compare everything queued for it.
  task automatic tick();
    @(posedge clk);
    #1;
    flush();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[24];
    int   lo_m, hi_m, hi_pulses;
    logic lo_rt_m, hi_rt_m, hi_en_m;

    tbl = '{
      '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 9, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 9, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 9, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 4'd1,  1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0}
    };

    // Reset held from time 0: outputs at reset values before any release.
    #1;
    push("reset_initial", 0, 0, 1'b0, 1'b0, 1'b0);
    flush();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    dir = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push($sformatf("pre_reset_up%0d", i), 0, i, 1'b0, 1'b0, 1'b0);
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    push("reset_async", 0, 0, 1'b0, 1'b0, 1'b0);
    flush();
    push("reset_held_edge", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    push("reset_released_hold", 0, 0, 1'b0, 1'b0, 1'b0);
    flush();
    push("first_edge_after_release", 0, 1, 1'b0, 1'b0, 1'b0);
    tick();

    // Free-running mod-32 up count with a single wrap pulse.
    clr = 1'b1;
    push("clr32", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      push($sformatf("up32_step%0d", i), 0, i % 32, (i == 32), 1'b0, 1'b0);
      tick();
    end

    // Mod-10 down count: 0 -> 9 wraps with rt, never shows 10..15.
    clr = 1'b1;
    push("clr10", 1, 0, 1'b0, 1'b0, 1'b0);
    tick();
    clr = 1'b0;
    dir = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      push($sformatf("down10_step%0d", i), 1, (10 - (i % 10)) % 10, ((i % 10) == 1), 1'b0, 1'b0);
      tick();
    end

    // Vector table on the mod-10 instance.
    for (int i = 0; i < 24; i++) begin
      clr      = tbl[i].clr;
      load     = tbl[i].load;
      load_val = {1'b0, tbl[i].lv};
      en       = tbl[i].en;
      dir      = tbl[i].dir;
      oneshot  = tbl[i].os;
      push($sformatf("vec%0d", i), 1, tbl[i].c, tbl[i].r, tbl[i].d, tbl[i].le);
      tick();
    end

    // Cascade: upper stage enabled by the lower stage's registered wrap pulse.
    load = 1'b0; load_val = '0; en = 1'b0; dir = 1'b1; oneshot = 1'b0;
    clr = 1'b1;
    push("cas_clr_lo", 2, 0, 1'b0, 1'b0, 1'b0);
    push("cas_clr_hi", 3, 0, 1'b0, 1'b0, 1'b0);
    tick();
    clr = 1'b0;
    cas_en = 1'b1;
    lo_m = 0; hi_m = 0; lo_rt_m = 1'b0; hi_rt_m = 1'b0; hi_pulses = 0;
    for (int i = 1; i <= 101; i++) begin
      hi_en_m = lo_rt_m;
      lo_rt_m = (lo_m == 9);
      lo_m    = (lo_m + 1) % 10;
      if (hi_en_m) begin
        hi_rt_m = (hi_m == 9);
        hi_m    = (hi_m + 1) % 10;
      end else begin
        hi_rt_m = 1'b0;
      end
      push($sformatf("cas_lo_clk%0d", i), 2, lo_m, lo_rt_m, 1'b0, 1'b0);
      push($sformatf("cas_hi_clk%0d", i), 3, hi_m, hi_rt_m, 1'b0, 1'b0);
      tick();
      if (rthi === 1'b1) hi_pulses++;
    end
    cas_en = 1'b0;
    total++;
    if (hi_pulses != 1) begin
      bad++;
      $display("FAIL cas_hi_rt_pulses: got %0d, want 1", hi_pulses);
    end else begin
      $display("ok   cas_hi_rt_pulses: %0d", hi_pulses);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
